// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter feeding the registered common data bus.
// One functional-unit result is granted per cycle; losers see req_busy and
// must hold their request. flush squashes the current cycle's grant.
module cdb_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TAG_BITS = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*TAG_BITS-1:0]   req_tag,
  input  logic [N_REQ*DATA_W-1:0]     req_value,
  input  logic                        flush,
  output logic [N_REQ-1:0]            req_grant,
  output logic [N_REQ-1:0]            req_busy,
  output logic                        cdb_valid,
  output logic [TAG_BITS-1:0]         cdb_tag,
  output logic [DATA_W-1:0]           cdb_value,
  output logic [$clog2(N_REQ)-1:0]    rr_ptr,
  output logic [15:0]                 conflict_cnt
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic                found;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    cidx;
  logic [PTR_W-1:0]    nxt_ptr;
  logic [TAG_BITS-1:0] gnt_tag;
  logic [DATA_W-1:0]   gnt_value;
  logic                multi_req;
  int unsigned         cand;

  // Priority search from rr_ptr upward (mod N_REQ); flush/reset kill the grant
  always_comb begin
    found     = 1'b0;
    gnt_idx   = '0;
    cidx      = '0;
    cand      = 0;
    req_grant = '0;
    gnt_tag   = '0;
    gnt_value = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % N_REQ;
      cidx = PTR_W'(cand);
      if (!found && req_valid[cidx]) begin
        found           = 1'b1;
        gnt_idx         = cidx;
        req_grant[cidx] = 1'b1;
        gnt_tag         = req_tag[cand*TAG_BITS +: TAG_BITS];
        gnt_value       = req_value[cand*DATA_W +: DATA_W];
      end
    end
    if (flush || !reset) begin
      found     = 1'b0;
      req_grant = '0;
    end
  end

  // Busy back-pressure, next pointer and contention detection
  always_comb begin
    req_busy  = (flush || !reset) ? '0 : (req_valid & ~req_grant);
    nxt_ptr   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    // clearing the lowest set bit leaves something only if >= 2 bits were set
    multi_req = |(req_valid & (req_valid - 1'b1));
  end

  // CDB output register, round-robin pointer and saturating conflict counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      cdb_valid    <= 1'b0;
      cdb_tag      <= '0;
      cdb_value    <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (found) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= gnt_tag;
        cdb_value <= gnt_value;
        rr_ptr    <= nxt_ptr;
      end else begin
        cdb_valid <= 1'b0;
        cdb_tag   <= '0;
        cdb_value <= '0;
      end
      if (multi_req && !flush && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a behavioural arbiter model predicts
// each cycle's grant and pushes the expected broadcast into a queue, which is
// popped and compared after the following clock edge.
module tb_cdb_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TB = 5;
  localparam int unsigned DW = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*TB-1:0]   req_tag;
  logic [N*DW-1:0]   req_value;
  logic              flush;
  logic [N-1:0]      req_grant;
  logic [N-1:0]      req_busy;
  logic              cdb_valid;
  logic [TB-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_value;
  logic [1:0]        rr_ptr;
  logic [15:0]       conflict_cnt;

  cdb_arbiter #(.N_REQ(N), .TAG_BITS(TB), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_tag(req_tag),
    .req_value(req_value), .flush(flush), .req_grant(req_grant),
    .req_busy(req_busy), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .rr_ptr(rr_ptr), .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          v;
    logic [TB-1:0] t;
    logic [DW-1:0] d;
  } bcast_t;

  bcast_t        sb_q[$];
  logic [TB-1:0] tag_of [N];
  logic [DW-1:0] val_of [N];
  int unsigned   m_ptr = 0;
  int unsigned   m_cnt = 0;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational grant/busy,
  // push the predicted broadcast, then pop and compare after the edge.
  task automatic cycle(input logic [N-1:0] v, input logic fl, input logic rst);
    logic [N-1:0] eg, eb;
    bit           hit;
    int unsigned  g, idx;
    bcast_t       e, o;
    @(negedge clock);
    req_valid = v;
    flush     = fl;
    reset     = rst;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TB +: TB]   = tag_of[i];
      req_value[i*DW +: DW] = val_of[i];
    end
    #1;
    eg = '0; hit = 0; g = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (!hit && v[idx]) begin hit = 1; g = idx; eg[idx] = 1'b1; end
    end
    if (!rst || fl) begin eg = '0; hit = 0; end
    eb = (rst && !fl) ? (v & ~eg) : '0;
    check("grant", 64'(req_grant), 64'(eg));
    check("busy", 64'(req_busy), 64'(eb));
    e = '0;
    if (rst && hit) begin e.v = 1'b1; e.t = tag_of[g]; e.d = val_of[g]; end
    sb_q.push_back(e);
    if (!rst) begin
      m_ptr = 0; m_cnt = 0;
    end else begin
      if (hit) m_ptr = (g + 1) % N;
      if (!fl && $countones(v) >= 2 && m_cnt < 16'hFFFF) m_cnt++;
    end
    @(posedge clock);
    #1;
    o = sb_q.pop_front();
    check("cdb_valid", 64'(cdb_valid), 64'(o.v));
    check("cdb_tag", 64'(cdb_tag), 64'(o.t));
    check("cdb_value", 64'(cdb_value), 64'(o.d));
    check("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  initial begin
    req_valid = '0; flush = 1'b0; reset = 1'b0; req_tag = '0; req_value = '0;
    for (int i = 0; i < N; i++) begin
      tag_of[i] = TB'(10 + i);
      val_of[i] = DW'(32'h100 + i);
    end

    // reset held with everybody requesting
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);

    // single request from unit 2
    tag_of[2] = 5'd3; val_of[2] = 32'h8;
    cycle(4'b0100, 1'b0, 1'b1);
    check("single_tag", 64'(cdb_tag), 64'd3);
    check("single_ptr", 64'(rr_ptr), 64'd3);

    // full contention from rr_ptr=0: request unit 3 once to wrap pointer to 0
    tag_of[2] = 5'd12; val_of[2] = 32'h102;
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b1);
    check("cont0_tag", 64'(cdb_tag), 64'd10);
    cycle(4'b1110, 1'b0, 1'b1);
    cycle(4'b1100, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    check("cont3_tag", 64'(cdb_tag), 64'd13);
    check("cont_cnt", 64'(conflict_cnt), 64'd3);

    // wrap-around: get rr_ptr to 3, then units 0 and 3 compete
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b1001, 1'b0, 1'b1);
    check("wrap_tag", 64'(cdb_tag), 64'd13);
    check("wrap_ptr", 64'(rr_ptr), 64'd0);
    cycle(4'b0001, 1'b0, 1'b1);

    // broadcast granted before a flush survives; flush kills the next one
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0110, 1'b1, 1'b1);
    check("flush_valid", 64'(cdb_valid), 64'd0);
    check("flush_ptr", 64'(rr_ptr), 64'd2);

    // idle gap, then reset mid-stream with conflict_cnt at 5
    cycle(4'b0011, 1'b0, 1'b1);
    tag_of[1] = 5'd7; val_of[1] = 32'hFF;
    cycle(4'b0010, 1'b0, 1'b1);
    check("idle_tag", 64'(cdb_tag), 64'd7);
    cycle(4'b0000, 1'b0, 1'b1);
    check("pre_rst_cnt", 64'(conflict_cnt), 64'd5);
    cycle(4'b0111, 1'b0, 1'b0);
    check("mid_rst_cnt", 64'(conflict_cnt), 64'd0);

    // drive the counter into saturation
    for (int i = 0; i < 65540; i++) cycle(4'b1111, 1'b0, 1'b1);
    check("sat_cnt", 64'(conflict_cnt), 64'hFFFF);
    cycle(4'b0011, 1'b0, 1'b1);
    check("sat_hold", 64'(conflict_cnt), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
